// File: rtl/viterbi_ber_checker.sv
// Viterbi BER checker: matches decoded bits against a FIFO of reference bits, waits for a
// run of matches before counting, then tracks bit errors and faults on FIFO or error-rate loss.
module viterbi_ber_checker #(
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned LOCK_RUN = 16,
    parameter int unsigned WIN      = 32,
    parameter int unsigned LOSS_THR = 8,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             ref_valid_i,
    input  logic             ref_bit_i,
    input  logic             dec_valid_i,
    input  logic             dec_bit_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] bits_checked_o,
    output logic [CNT_W-1:0] bit_errors_o,
    output logic             locked_o,
    output logic             fault_o,
    output logic             ovf_o,
    output logic             unf_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned RW = $clog2(LOCK_RUN + 1);
    localparam int unsigned WW = $clog2(WIN + 1);

    typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK, FAULT} state_t;
    state_t state, state_next;

    logic [DEPTH-1:0] mem;
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             full, empty, active, flag_ok;
    logic             push_req, pop_req, do_push, do_pop, ovf_evt, unf_evt;
    logic             cmp_valid, cmp_err, err_evt;
    logic [RW-1:0]    run_cnt;
    logic [WW-1:0]    win_bits, win_errs;
    logic             lock_hit, loss_hit, win_end;

    always_comb begin
        empty    = (wr_ptr == rd_ptr);
        full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        active   = (state != IDLE);
        flag_ok  = (state == ACQUIRE) || (state == TRACK);
        push_req = active && ref_valid_i;
        pop_req  = active && dec_valid_i;
        // An empty FIFO never bypasses a same-cycle push to the pop side.
        do_pop   = pop_req && !empty;
        do_push  = push_req && (!full || do_pop);
        ovf_evt  = push_req && full && !pop_req;
        unf_evt  = pop_req && empty;
        lock_hit = (state == ACQUIRE) && cmp_valid && !cmp_err
                   && ((32'(run_cnt) + 32'd1) == LOCK_RUN);
        loss_hit = (state == TRACK) && cmp_valid && cmp_err
                   && ((32'(win_errs) + 32'd1) == LOSS_THR);
        win_end  = ((32'(win_bits) + 32'd1) == WIN);
    end

    always_comb begin
        state_next = state;
        if (!en_i) begin
            state_next = IDLE;
        end else if (clear_i) begin
            state_next = ACQUIRE;
        end else begin
            case (state)
                IDLE:    state_next = ACQUIRE;
                ACQUIRE: begin
                    if (err_evt)       state_next = FAULT;
                    else if (lock_hit) state_next = TRACK;
                end
                TRACK:   begin
                    if (err_evt || loss_hit) state_next = FAULT;
                end
                FAULT:   state_next = FAULT;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst || !en_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= ref_bit_i;
    end

    // Comparison results land one cycle after the pop; counters and FSM act on the registered copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            bits_checked_o <= '0;
            bit_errors_o   <= '0;
            ovf_o          <= 1'b0;
            unf_o          <= 1'b0;
            cmp_valid      <= 1'b0;
            cmp_err        <= 1'b0;
            err_evt        <= 1'b0;
            run_cnt        <= '0;
            win_bits       <= '0;
            win_errs       <= '0;
        end else if (!en_i) begin
            cmp_valid <= 1'b0;
            err_evt   <= 1'b0;
            run_cnt   <= '0;
            win_bits  <= '0;
            win_errs  <= '0;
        end else if (clear_i) begin
            bits_checked_o <= '0;
            bit_errors_o   <= '0;
            ovf_o          <= 1'b0;
            unf_o          <= 1'b0;
            cmp_valid      <= 1'b0;
            err_evt        <= 1'b0;
            run_cnt        <= '0;
            win_bits       <= '0;
            win_errs       <= '0;
        end else begin
            cmp_valid <= do_pop && flag_ok;
            cmp_err   <= mem[rd_ptr[AW-1:0]] ^ dec_bit_i;
            err_evt   <= flag_ok && (ovf_evt || unf_evt);
            if (flag_ok && ovf_evt) ovf_o <= 1'b1;
            if (flag_ok && unf_evt) unf_o <= 1'b1;

            if (cmp_valid && state == ACQUIRE) begin
                if (cmp_err || lock_hit) run_cnt <= '0;
                else                     run_cnt <= run_cnt + 1'b1;
                if (lock_hit) begin
                    win_bits <= '0;
                    win_errs <= '0;
                end
            end

            if (cmp_valid && state == TRACK) begin
                if (bits_checked_o != '1) bits_checked_o <= bits_checked_o + 1'b1;
                if (cmp_err && bit_errors_o != '1) bit_errors_o <= bit_errors_o + 1'b1;
                if (win_end) begin
                    win_bits <= '0;
                    win_errs <= '0;
                end else begin
                    win_bits <= win_bits + 1'b1;
                    win_errs <= win_errs + WW'(cmp_err);
                end
            end
        end
    end

    assign locked_o = (state == TRACK);
    assign fault_o  = (state == FAULT);

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Directed bench for viterbi_ber_checker: a reference queue mirrors FIFO contents and a
// result queue applies expected counter updates one cycle after each decoded bit is driven.
module tb_viterbi_ber_checker;
    logic clk = 1'b0;
    logic rst, en_a, en_b, ref_valid, ref_bit, dec_valid, dec_bit, clear;
    logic [31:0] bits_a, errs_a;
    logic        locked_a, fault_a, ovf_a, unf_a;
    logic [3:0]  bits_b, errs_b;
    logic        locked_b, fault_b, ovf_b, unf_b;

    typedef struct {
        int stamp;
        bit mis;
    } res_t;

    bit          ref_q[$];
    res_t        res_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_bits, exp_errs;
    int          lock_at, fault_at;

    always #5 clk = ~clk;

    viterbi_ber_checker u_dut (
        .clk(clk), .rst(rst), .en_i(en_a),
        .ref_valid_i(ref_valid), .ref_bit_i(ref_bit),
        .dec_valid_i(dec_valid), .dec_bit_i(dec_bit), .clear_i(clear),
        .bits_checked_o(bits_a), .bit_errors_o(errs_a),
        .locked_o(locked_a), .fault_o(fault_a), .ovf_o(ovf_a), .unf_o(unf_a)
    );

    viterbi_ber_checker #(.DEPTH(8), .LOCK_RUN(4), .WIN(4), .LOSS_THR(8), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .en_i(en_b),
        .ref_valid_i(ref_valid), .ref_bit_i(ref_bit),
        .dec_valid_i(dec_valid), .dec_bit_i(dec_bit), .clear_i(clear),
        .bits_checked_o(bits_b), .bit_errors_o(errs_b),
        .locked_o(locked_b), .fault_o(fault_b), .ovf_o(ovf_b), .unf_o(unf_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pushes n_push random bits and pops n_pop of them starting at cycle lag; compare index pj
    // is counted only in [skip, skip+take) and flipped per flip_mod / the run window.
    task automatic stream(input bit sat, input int n_push, input int n_pop, input int lag,
                          input int skip, input int take, input int flip_mod,
                          input int run_start, input int run_len, input int depth);
        int          total, pj;
        bit          popping, rb, flip;
        logic [31:0] max_cnt, obs_b, obs_e;
        res_t        r;
        total    = (n_push > lag + n_pop) ? n_push : lag + n_pop;
        max_cnt  = sat ? 32'd15 : 32'hFFFF_FFFF;
        pj       = 0;
        lock_at  = -1;
        fault_at = -1;
        for (int i = 0; i <= total; i++) begin
            popping   = (i >= lag) && (i < lag + n_pop);
            dec_valid = popping;
            dec_bit   = 1'b0;
            if (popping) begin
                flip = (flip_mod != 0) ? ((pj % flip_mod) == flip_mod - 1) : 1'b0;
                if (pj >= run_start && pj < run_start + run_len) flip = 1'b1;
                dec_bit = ref_q.pop_front() ^ flip;
                if (pj >= skip && pj < skip + take) begin
                    r.stamp = i;
                    r.mis   = flip;
                    res_q.push_back(r);
                end
                pj++;
            end
            ref_valid = (i < n_push);
            rb        = 1'($urandom_range(0, 1));
            ref_bit   = rb;
            if (ref_valid && ref_q.size() < depth) ref_q.push_back(rb);
            step();
            while (res_q.size() > 0 && res_q[0].stamp < i) begin
                r = res_q.pop_front();
                if (exp_bits != max_cnt) exp_bits++;
                if (r.mis && exp_errs != max_cnt) exp_errs++;
            end
            if (sat) begin
                obs_b = 32'(bits_b);
                obs_e = 32'(errs_b);
                if (lock_at < 0 && locked_b) lock_at = i;
                if (fault_at < 0 && fault_b) fault_at = i;
            end else begin
                obs_b = bits_a;
                obs_e = errs_a;
                if (lock_at < 0 && locked_a) lock_at = i;
                if (fault_at < 0 && fault_a) fault_at = i;
            end
            check("stream_bits", obs_b, exp_bits);
            check("stream_errs", obs_e, exp_errs);
        end
        dec_valid = 1'b0;
        ref_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en_a = 1'b0; en_b = 1'b0; clear = 1'b0;
        ref_valid = 1'b0; ref_bit = 1'b0; dec_valid = 1'b0; dec_bit = 1'b0;
        exp_bits = '0; exp_errs = '0;
        step(); step();
        check("rst_bits", bits_a, 0);
        check("rst_errs", errs_a, 0);
        check("rst_locked", 32'(locked_a), 0);
        check("rst_fault", 32'(fault_a), 0);
        check("rst_ovf", 32'(ovf_a), 0);
        check("rst_unf", 32'(unf_a), 0);
        check("rst_sat_bits", 32'(bits_b), 0);

        // Error-free 100 bits with a 20-cycle lag
        rst = 1'b0; en_a = 1'b1;
        step();
        stream(1'b0, 100, 100, 20, 16, 1000, 0, 0, 0, 64);
        check("lock_cycle", lock_at, 36);
        check("clean_bits", bits_a, 84);
        check("clean_errs", errs_a, 0);
        check("clean_locked", 32'(locked_a), 1);

        // One flip in every eight stays below the loss threshold
        stream(1'b0, 64, 64, 2, 0, 1000, 8, 0, 0, 64);
        check("sparse_fault_at", fault_at, -1);
        check("sparse_bits", bits_a, 148);
        check("sparse_errs", errs_a, 8);
        check("sparse_locked", 32'(locked_a), 1);

        // Finish the current window cleanly, then eight consecutive flips
        stream(1'b0, 24, 24, 2, 0, 20, 0, 12, 8, 64);
        check("burst_fault_at", fault_at, 22);
        check("burst_fault", 32'(fault_a), 1);
        check("burst_locked", 32'(locked_a), 0);
        step(); step();
        check("frozen_bits", bits_a, 168);
        check("frozen_errs", errs_a, 16);

        // Disable, re-enable, then overflow with 65 pushes
        en_a = 1'b0;
        step();
        check("idle_fault", 32'(fault_a), 0);
        check("idle_locked", 32'(locked_a), 0);
        en_a = 1'b1;
        step();
        stream(1'b0, 65, 0, 0, 0, 0, 0, 0, 0, 64);
        check("ovf_set", 32'(ovf_a), 1);
        check("ovf_fault_at", fault_at, 65);
        clear = 1'b1;
        step();
        clear = 1'b0;
        exp_bits = '0; exp_errs = '0;
        check("clr_ovf", 32'(ovf_a), 0);
        check("clr_fault", 32'(fault_a), 0);
        check("clr_locked", 32'(locked_a), 0);
        check("clr_bits", bits_a, 0);
        check("clr_errs", errs_a, 0);
        stream(1'b0, 0, 64, 0, 16, 1000, 0, 0, 0, 64);
        check("drain_lock_at", lock_at, 16);
        check("drain_bits", bits_a, 48);
        check("drain_unf", 32'(unf_a), 0);

        // Pop on empty with a same-cycle push: underflow, push still stored
        ref_bit = 1'($urandom_range(0, 1));
        ref_q.push_back(ref_bit);
        ref_valid = 1'b1; dec_valid = 1'b1; dec_bit = 1'b0;
        step();
        ref_valid = 1'b0; dec_valid = 1'b0;
        check("unf_set", 32'(unf_a), 1);
        check("unf_fault_early", 32'(fault_a), 0);
        step();
        check("unf_fault", 32'(fault_a), 1);
        check("unf_bits", bits_a, 48);
        clear = 1'b1;
        step();
        clear = 1'b0;
        exp_bits = '0; exp_errs = '0;
        check("clr2_unf", 32'(unf_a), 0);
        check("clr2_fault", 32'(fault_a), 0);
        check("clr2_bits", bits_a, 0);
        dec_valid = 1'b1;
        dec_bit = ref_q.pop_front();
        step();
        dec_valid = 1'b0;
        step();
        check("stored_unf", 32'(unf_a), 0);
        stream(1'b0, 20, 20, 2, 15, 1000, 0, 0, 0, 64);
        check("relock_at", lock_at, 17);
        check("relock_bits", bits_a, 5);

        // Reset mid-TRACK with bits in the FIFO
        ref_valid = 1'b1;
        repeat (3) step();
        ref_valid = 1'b0;
        check("pre_rst_locked", 32'(locked_a), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        ref_q.delete();
        exp_bits = '0; exp_errs = '0;
        check("mid_rst_bits", bits_a, 0);
        check("mid_rst_errs", errs_a, 0);
        check("mid_rst_locked", 32'(locked_a), 0);
        check("mid_rst_fault", 32'(fault_a), 0);
        check("mid_rst_ovf", 32'(ovf_a), 0);
        check("mid_rst_unf", 32'(unf_a), 0);
        step();
        dec_valid = 1'b1;
        step();
        dec_valid = 1'b0;
        check("flushed_unf", 32'(unf_a), 1);
        en_a = 1'b0; clear = 1'b1;
        step();
        clear = 1'b0;
        check("en_over_clear_unf", 32'(unf_a), 1);

        // Saturation on a 4-bit-counter instance
        en_b = 1'b1;
        step();
        stream(1'b1, 21, 21, 1, 4, 1000, 0, 4, 1000, 8);
        check("sat_lock_at", lock_at, 5);
        check("sat_bits", 32'(bits_b), 15);
        check("sat_errs", 32'(errs_b), 15);
        check("sat_locked", 32'(locked_b), 1);
        check("sat_fault", 32'(fault_b), 0);
        en_b = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
